// File: rtl/fifo_ms_read_sched_if.sv
// fifo_ms_read_sched_if: fifo_ms read-port and downstream valid/ready bundle for the read scheduler
interface fifo_ms_read_sched_if #(
  parameter int DATA_WIDTH = 32,
  parameter int FLUX = 4
);
  localparam int TW = (FLUX > 1) ? $clog2(FLUX) : 1;
  logic [FLUX-1:0] en_mask;
  logic [FLUX-1:0] fifo_empty;
  logic [FLUX-1:0] fifo_read;
  logic [DATA_WIDTH+TW-1:0] fifo_dout;
  logic [DATA_WIDTH-1:0] m_data;
  logic [TW-1:0] m_tag;
  logic m_valid;
  logic m_ready;
  logic [TW-1:0] grant_id;
  logic busy;
  logic tag_err;
  modport master (
    input en_mask, fifo_empty, fifo_dout, m_ready,
    output fifo_read, m_data, m_tag, m_valid, grant_id, busy, tag_err
  );
  modport slave (
    output en_mask, fifo_empty, fifo_dout, m_ready,
    input fifo_read, m_data, m_tag, m_valid, grant_id, busy, tag_err
  );
endinterface

// File: rtl/fifo_ms_read_sched.sv
// fifo_ms_read_sched: round-robin burst read scheduler for fifo_ms with a 2-entry output buffer
module fifo_ms_read_sched #(
  parameter int DATA_WIDTH = 32,
  parameter int FLUX = 4,
  parameter int BURST = 4
) (
  input logic clk,
  input logic rst,
  fifo_ms_read_sched_if.master bus
);
  localparam int TW = (FLUX > 1) ? $clog2(FLUX) : 1;
  localparam int WW = DATA_WIDTH + TW;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SERVE = 1'b1;
  logic [0:0] state;
  logic [TW-1:0] rr_ptr, grant_id, rd_id, pick, nxt_ptr;
  logic [7:0] burst_cnt;
  logic [1:0] cnt, occ, slot;
  logic [WW-1:0] e0, e1;
  logic in_flight, found, rd, pop, push, last, leave, tag_err;
  assign push = in_flight;
  assign pop = cnt != 2'd0 && bus.m_ready;
  assign slot = cnt - 2'(pop);
  // a buffer slot drained this cycle is already free, which keeps bursts gapless at m_ready=1
  assign occ = slot + 2'(in_flight);
  assign rd = state == SERVE && bus.en_mask[grant_id] && !bus.fifo_empty[grant_id] && !occ[1] && burst_cnt < 8'(BURST);
  assign last = rd && burst_cnt == 8'(BURST - 1);
  assign leave = burst_cnt == 8'(BURST) || bus.fifo_empty[grant_id] || !bus.en_mask[grant_id] || last;
  assign nxt_ptr = grant_id == TW'(FLUX - 1) ? '0 : grant_id + TW'(1);
  // first eligible stream at or after rr_ptr; descending scan so the nearest one wins
  always_comb begin
    found = 1'b0;
    pick = '0;
    for (int i = FLUX - 1; i >= 0; i--)
      if (bus.en_mask[(int'(rr_ptr) + i) % FLUX] && !bus.fifo_empty[(int'(rr_ptr) + i) % FLUX]) begin
        found = 1'b1;
        pick = TW'((int'(rr_ptr) + i) % FLUX);
      end
  end
  // grant FSM: arbitrate in IDLE, issue reads in SERVE until quantum, empty or mask ends the grant
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      rr_ptr <= '0;
      grant_id <= '0;
      burst_cnt <= '0;
    end else if (state == IDLE) begin
      if (found) begin
        state <= SERVE;
        grant_id <= pick;
        burst_cnt <= '0;
      end
    end else begin
      if (rd) burst_cnt <= burst_cnt + 8'd1;
      if (leave) begin
        state <= IDLE;
        rr_ptr <= nxt_ptr;
      end
    end
  // in-flight tracking and sticky tag check of the returned word against the stream read
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      in_flight <= 1'b0;
      rd_id <= '0;
      tag_err <= 1'b0;
    end else begin
      in_flight <= rd;
      if (rd) rd_id <= grant_id;
      if (push && bus.fifo_dout[WW-1:DATA_WIDTH] != rd_id) tag_err <= 1'b1;
    end
  // 2-entry output buffer, head in e0; push lands in the first slot left after a pop
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cnt <= '0;
      e0 <= '0;
      e1 <= '0;
    end else begin
      cnt <= slot + 2'(push);
      if (pop) e0 <= e1;
      if (push && slot == 2'd0) e0 <= bus.fifo_dout;
      if (push && slot == 2'd1) e1 <= bus.fifo_dout;
    end
  assign bus.fifo_read = rd ? FLUX'(1) << grant_id : '0;
  assign bus.m_valid = cnt != 2'd0;
  assign bus.m_data = e0[DATA_WIDTH-1:0];
  assign bus.m_tag = e0[WW-1:DATA_WIDTH];
  assign bus.grant_id = grant_id;
  assign bus.busy = state == SERVE;
  assign bus.tag_err = tag_err;
endmodule

// File: tb/tb_fifo_ms_read_sched.sv
// tb_fifo_ms_read_sched: directed vectors plus corner sequences against a fifo_ms queue model
module tb_fifo_ms_read_sched;
  localparam int DW = 32;
  localparam int FLUX = 4;
  localparam int TW = 2;
  localparam int BURST = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic corrupt = 1'b0;
  int errors = 0;
  int checks = 0;
  int viol = 0;
  int rd_cnt[FLUX] = '{default: 0};
  int ld_idx[FLUX];
  logic [DW-1:0] q[FLUX][$];
  logic [TW-1:0] got_tag[$];
  logic [DW-1:0] got_data[$];
  logic pend = 1'b0;
  logic [DW-1:0] pd = '0;
  logic [TW-1:0] pt = '0;
  typedef struct {
    string name;
    int n0, n1, n2, n3;
    logic [3:0] mask;
    string exp;
  } vec_t;
  vec_t tv[5];
  always #5 clk = ~clk;
  fifo_ms_read_sched_if #(.DATA_WIDTH(DW), .FLUX(FLUX)) bus ();
  fifo_ms_read_sched #(.DATA_WIDTH(DW), .FLUX(FLUX), .BURST(BURST)) dut (.clk(clk), .rst(rst), .bus(bus));
  // fifo_ms model: 1-cycle read latency, empty flags reflect post-read state after the edge
  always @(posedge clk)
    for (int s = 0; s < FLUX; s++) begin
      if (bus.fifo_read[s] && q[s].size() > 0) begin
        bus.fifo_dout <= {corrupt ? 2'd3 : TW'(s), q[s][0]};
        q[s].pop_front();
        rd_cnt[s] <= rd_cnt[s] + 1;
      end
      bus.fifo_empty[s] <= q[s].size() == 0;
    end
  // consumer capture and read-strobe / hold-stability protocol monitor
  always @(negedge clk)
    if (rst) begin
      if (bus.m_valid && bus.m_ready) begin
        got_tag.push_back(bus.m_tag);
        got_data.push_back(bus.m_data);
      end
      if (bus.fifo_read != '0 && (!$onehot(bus.fifo_read) || !bus.busy || (bus.fifo_read & ~bus.en_mask) != '0 ||
          (bus.fifo_read & bus.fifo_empty) != '0 || bus.fifo_read != (4'b1 << bus.grant_id))) begin
        viol <= viol + 1;
        $display("protocol violation t=%0t read=%b empty=%b mask=%b", $time, bus.fifo_read, bus.fifo_empty, bus.en_mask);
      end
      if (pend && (!bus.m_valid || bus.m_data != pd || bus.m_tag != pt)) begin
        viol <= viol + 1;
        $display("hold violation t=%0t", $time);
      end
      pend <= bus.m_valid && !bus.m_ready;
      pd <= bus.m_data;
      pt <= bus.m_tag;
    end else pend <= 1'b0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic do_reset();
    bus.m_ready = 1'b0;
    bus.en_mask = '0;
    rst = 1'b0;
    for (int s = 0; s < FLUX; s++) begin
      q[s].delete();
      ld_idx[s] = 0;
    end
    got_tag.delete();
    got_data.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask
  task automatic load(input int s, input int n);
    for (int i = 0; i < n; i++) begin
      q[s].push_back(32'hA000_0000 + s * 256 + ld_idx[s]);
      ld_idx[s]++;
    end
  endtask
  task automatic wait_words(input int n);
    for (int c = 0; c < 300 && got_tag.size() < n; c++) @(posedge clk);
    #1;
  endtask
  task automatic verify(input string nm, input string exp);
    int k[FLUX];
    for (int s = 0; s < FLUX; s++) k[s] = 0;
    chk({nm, " count"}, got_tag.size(), exp.len());
    for (int i = 0; i < exp.len() && i < got_tag.size(); i++) begin
      int t;
      t = exp[i] - 48;
      chk($sformatf("%s tag[%0d]", nm, i), got_tag[i], t);
      chk($sformatf("%s data[%0d]", nm, i), got_data[i], 32'hA000_0000 + t * 256 + k[t]);
      k[t]++;
    end
  endtask
  initial begin
    int b, v0;
    logic seen;
    tv[0] = '{"single", 0, 0, 3, 0, 4'hf, "222"};
    tv[1] = '{"round_robin", 8, 8, 8, 8, 4'hf, "00001111222233330000111122223333"};
    tv[2] = '{"uneven", 2, 5, 0, 1, 4'hf, "00111131"};
    tv[3] = '{"masked", 3, 3, 3, 3, 4'b1010, "111333"};
    tv[4] = '{"requantum", 5, 0, 0, 0, 4'hf, "00000"};
    bus.m_ready = 1'b0;
    bus.en_mask = '0;
    #2 rst = 1'b0;
    #1;
    chk("reset fifo_read", bus.fifo_read, 0);
    chk("reset m_valid", bus.m_valid, 0);
    chk("reset m_data", bus.m_data, 0);
    chk("reset m_tag", bus.m_tag, 0);
    chk("reset busy", bus.busy, 0);
    chk("reset tag_err", bus.tag_err, 0);
    chk("reset grant_id", bus.grant_id, 0);
    for (int v = 0; v < 5; v++) begin
      do_reset();
      load(0, tv[v].n0);
      load(1, tv[v].n1);
      load(2, tv[v].n2);
      load(3, tv[v].n3);
      v0 = viol;
      bus.en_mask = tv[v].mask;
      bus.m_ready = 1'b1;
      wait_words(tv[v].exp.len());
      repeat (8) @(posedge clk);
      #1;
      verify(tv[v].name, tv[v].exp);
      chk({tv[v].name, " busy end"}, bus.busy, 0);
      chk({tv[v].name, " m_valid end"}, bus.m_valid, 0);
      chk({tv[v].name, " protocol"}, viol - v0, 0);
      chk({tv[v].name, " tag_err"}, bus.tag_err, 0);
    end
    do_reset();
    load(0, 6);
    v0 = viol;
    b = rd_cnt[0];
    bus.en_mask = 4'hf;
    repeat (12) @(posedge clk);
    #1;
    chk("bp reads", rd_cnt[0] - b, 2);
    chk("bp m_valid", bus.m_valid, 1);
    chk("bp m_data", bus.m_data, 32'hA000_0000);
    repeat (3) @(posedge clk);
    #1;
    chk("bp held m_data", bus.m_data, 32'hA000_0000);
    chk("bp held m_tag", bus.m_tag, 0);
    bus.m_ready = 1'b1;
    wait_words(6);
    verify("bp", "000000");
    chk("bp protocol", viol - v0, 0);
    do_reset();
    load(1, 6);
    load(2, 2);
    v0 = viol;
    b = rd_cnt[1];
    bus.en_mask = 4'hf;
    bus.m_ready = 1'b1;
    for (int c = 0; c < 50 && rd_cnt[1] - b < 2; c++) begin
      @(posedge clk);
      #1;
    end
    bus.en_mask = 4'b1101;
    wait_words(4);
    repeat (8) @(posedge clk);
    #1;
    verify("mask", "1122");
    chk("mask reads1", rd_cnt[1] - b, 2);
    chk("mask busy end", bus.busy, 0);
    chk("mask protocol", viol - v0, 0);
    do_reset();
    load(0, 2);
    b = rd_cnt[0];
    corrupt = 1'b1;
    bus.en_mask = 4'hf;
    bus.m_ready = 1'b1;
    for (int c = 0; c < 50 && rd_cnt[0] - b < 1; c++) begin
      @(posedge clk);
      #1;
    end
    corrupt = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("tagerr set", bus.tag_err, 1);
    chk("tagerr word tag", got_tag.size() > 0 ? got_tag[0] : 2'd0, 3);
    repeat (10) @(posedge clk);
    #1;
    chk("tagerr sticky", bus.tag_err, 1);
    #3 rst = 1'b0;
    #1;
    chk("tagerr cleared", bus.tag_err, 0);
    do_reset();
    load(0, 1);
    load(1, 8);
    b = rd_cnt[1];
    bus.en_mask = 4'hf;
    bus.m_ready = 1'b1;
    for (int c = 0; c < 50 && rd_cnt[1] - b < 2; c++) begin
      @(posedge clk);
      #1;
    end
    #3 rst = 1'b0;
    #1;
    chk("arst fifo_read", bus.fifo_read, 0);
    chk("arst m_valid", bus.m_valid, 0);
    chk("arst busy", bus.busy, 0);
    load(2, 3);
    load(0, 2);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 30 && !seen; c++) begin
      @(negedge clk);
      seen = bus.fifo_read != '0;
    end
    chk("arst restart", bus.fifo_read, 4'b0001);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fifo_ms_read_sched.md
Name: fifo_ms_read_sched

Overview:
- Read-side scheduler for the multi-stream FIFO `fifo_ms` (FLUX streams, tagged words).
- Drains non-empty, enabled streams in round-robin order, with a burst quantum per grant.
- Generates the one-hot per-stream read strobes and splits each returned word into data and tag.
- Delivers words to a single downstream valid/ready consumer through a 2-entry output buffer. It sits between `fifo_ms` read_port and the consumer datapath.

Parameters:
- DATA_WIDTH, 32, payload width of each FIFO word.
- FLUX, 4, number of streams; tag width TW = $clog2(FLUX).
- BURST, 4, maximum words read from one stream per grant (1..255).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- en_mask  in  FLUX  per-stream enable; 0 excludes the stream from arbitration.
- fifo_empty  in  FLUX  empty flags from `fifo_ms`.
- fifo_read  out  FLUX  read strobes to `fifo_ms`; one-hot or zero.
- fifo_dout  in  DATA_WIDTH+TW  FIFO word, laid out as {tag, data} with the tag in the MSBs.
- m_data  out  DATA_WIDTH  output payload.
- m_tag  out  TW  output stream tag.
- m_valid  out  1  output word valid.
- m_ready  in  1  consumer accepts the word when m_valid & m_ready.
- grant_id  out  TW  stream currently granted.
- busy  out  1  high in SERVE.
- tag_err  out  1  sticky; set when the returned tag differs from the stream that was read.

Behaviour:
- Reset (rst=0, async):
  - State IDLE; rr_ptr=0; grant_id=0; burst_cnt=0.
  - fifo_read=0; m_valid=0; m_data=0; m_tag=0; busy=0; tag_err=0.
  - Output buffer and in-flight tracking cleared. A read in flight at reset is discarded.
- FIFO timing: `fifo_ms` returns fifo_dout on the cycle after a fifo_read pulse (1-cycle read latency). fifo_empty reflects the post-read state one cycle after the edge.
- Credit rule: occ = buffered words + reads in flight. A read may issue only when occ < 2. This guarantees no word is lost when m_ready is low.
- State IDLE:
  - Search streams rr_ptr, rr_ptr+1, ... mod FLUX for the first stream with en_mask=1 and fifo_empty=0.
  - If one is found: grant_id <= that stream, burst_cnt <= 0, go to SERVE.
  - No read is issued in IDLE.
- State SERVE:
  - Issue fifo_read[grant_id]=1 in a cycle when en_mask[grant_id]=1, fifo_empty[grant_id]=0, occ<2 and burst_cnt<BURST. Each issued read increments burst_cnt.
  - Exit to IDLE when any of the following holds, setting rr_ptr <= grant_id+1 mod FLUX:
    - burst_cnt==BURST;
    - fifo_empty[grant_id]=1;
    - en_mask[grant_id]=0.
  - Credit stalls (occ==2) keep SERVE without a read.
- Masking mid-grant: dropping en_mask inhibits fifo_read combinationally in the same cycle. A word already in flight is still captured and delivered.
- Returned word handling:
  - Split fifo_dout into m_tag (MSBs) and m_data and push it into the buffer.
  - Compare the returned tag with the stream that was read; a mismatch sets tag_err until reset.
- Output ordering and timing:
  - FIFO order; m_valid=1 whenever the buffer is non-empty.
  - m_data/m_tag are held stable while m_valid & ~m_ready.
  - Push and pop in the same cycle are allowed (occupancy unchanged).
- Latency: first word appears on m_valid 3 cycles after the first eligible stream appears in IDLE (arbitrate, read, capture).
- Throughput: 1 word/cycle within a burst while m_ready=1, plus 1 idle-arbitration cycle per grant change.
- Fairness: rr_ptr always advances past the served stream, so with all streams busy each gets BURST words per round.
- fifo_read is never asserted in IDLE, never to a stream reporting empty, and never to a masked stream.

Test Plan:
- Single stream: stream 2 holds 3 words, m_ready=1 → fifo_read=4'b0100 for 3 consecutive cycles; m_tag=2 ×3 in order; then IDLE, busy=0.
- Round-robin: all 4 streams hold 8 words, BURST=4 → grant order 0,1,2,3,0,1,2,3; exactly 4 reads per grant; 32 words total, no gaps within a burst.
- Backpressure: stream 0 holds 6 words, m_ready=0 → exactly 2 reads issued, m_valid=1 with the first word held stable. On release, all 6 words arrive in order with none dropped.
- Mask mid-burst: drop en_mask[1] after 2 reads of stream 1 → no further fifo_read[1] from that cycle; the in-flight word is still delivered; the next grant goes to stream 2.
- Tag error: fifo_dout tag=3 returned for a read of stream 0 → tag_err=1 and it stays 1 until rst=0.
- Async reset mid-burst: assert rst=0 between clock edges during SERVE → fifo_read=0, m_valid=0, busy=0 immediately; after release, arbitration restarts from stream 0.
